// File: rtl/vga_scan_out.sv
// rtl/vga_scan_out.sv - VGA raster timing generator with registered colour/sync output stage (optional border: VGA_BORDER_EN)
module vga_scan_out #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rgb_in,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       visible,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LASTPIX = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LASTLN  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [1:0] DIV_LAST   = 2'(CLK_DIV - 1);

    logic [1:0] div_q, div_d;
    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       tick;
    logic       wrap;
    logic       hs_n, vs_n;
    logic [7:0] colour_q, colour_d;
    logic       hsync_q, vsync_q;
    logic       frame_start_q;

    // With CLK_DIV=1 the divider sits at 0 and tick is permanently high.
    assign tick = (div_q == DIV_LAST);
    assign wrap = tick && (hcount_q == H_LAST) && (vcount_q == V_LAST);

    assign visible = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    assign hs_n    = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LASTPIX));
    assign vs_n    = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LASTLN));

    // Divider and scan counter next-state; counters move only on pixel ticks.
    always_comb begin
        div_d    = tick ? 2'd0 : div_q + 2'd1;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (tick) begin
            if (hcount_q == H_LAST) begin
                hcount_d = 10'd0;
                vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

`ifdef VGA_BORDER_EN
    logic on_border;
    assign on_border = visible &&
                       ((hcount_q == 10'd0) || (hcount_q == H_VIS - 10'd1) ||
                        (vcount_q == 10'd0) || (vcount_q == V_VIS - 10'd1));

    // Colour to load on the next tick: white frame on the visible perimeter, black in blanking.
    always_comb begin
        colour_d = 8'h00;
        if (visible) colour_d = on_border ? 8'hFF : rgb_in;
    end
`else
    // Colour to load on the next tick: pass-through when visible, black in blanking.
    always_comb begin
        colour_d = 8'h00;
        if (visible) colour_d = rgb_in;
    end
`endif

    // Divider and scan position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= 2'd0;
            hcount_q <= 10'd0;
            vcount_q <= 10'd0;
        end else begin
            div_q    <= div_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    // Output stage: one pixel behind the counters so sync and colour stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            colour_q <= 8'h00;
        end else if (tick) begin
            hsync_q  <= hs_n;
            vsync_q  <= vs_n;
            colour_q <= colour_d;
        end
    end

    // Single-clk pulse in the cycle after the scan wraps back to (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_start_q <= 1'b0;
        else     frame_start_q <= wrap;
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign frame_start = frame_start_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = colour_q[7:5];
    assign green       = colour_q[4:2];
    assign blue        = colour_q[1:0];

endmodule

// File: doc/vga_scan_out.md
# vga_scan_out

Raster timing generator and registered colour output stage for the Space Invaders display. It sits directly downstream of the colour-code-to-RGB mapper, which turns a 3-bit colour code into an 8-bit RGB332 word. The block generates the pixel scan position (`hcount`/`vcount`), which the upstream scene logic uses to pick a colour. It then samples the resulting RGB word one pixel later and drives the VGA pins (`hsync`, `vsync`, `red`, `green`, `blue`) with matching alignment.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `CLK_DIV`, 2, system clocks per pixel; valid range 1..4
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rgb_in`  in  8  RGB332 from upstream mapper: [7:5] red, [4:2] green, [1:0] blue
- `hcount`  out  10  current pixel column, 0..799
- `vcount`  out  10  current line, 0..524
- `visible`  out  1  1 when `hcount < H_VISIBLE` and `vcount < V_VISIBLE` (combinational from counters)
- `frame_start`  out  1  one-clk pulse after the counters wrap to (0,0)
- `hsync`  out  1  active-low horizontal sync to pin
- `vsync`  out  1  active-low vertical sync to pin
- `red`  out  3  red to DAC
- `green`  out  3  green to DAC
- `blue`  out  2  blue to DAC

## Operation
- Pixel tick:
  - A divider counter runs 0..`CLK_DIV`-1.
  - `tick` = (div == `CLK_DIV`-1).
  - With `CLK_DIV`=1, `tick` is constantly 1.
- Scan counters advance only on `tick`:
  - `hcount` increments and wraps 799→0; on that wrap, `vcount` increments.
  - `vcount` wraps 524→0.
  - Line and frame totals are the sums of the four respective parameters (800 and 525 by default).
- Sync decode, from current counters:
  - hs_n = 0 iff `hcount` is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751.
  - vs_n = 0 iff `vcount` is in [490, 491].
- Output stage (one pixel of latency):
  - On each `tick`, register `hsync`←hs_n, `vsync`←vs_n, and colour ← `visible` ? `rgb_in` : 0.
  - `rgb_in` is combinational from the current `hcount`/`vcount` through upstream logic, so pixel (h,v) is on the pins during the pixel period after the one where (h,v) was on the counters.
- Colour is forced to 0 in all blanking intervals; sync outputs are never affected by colour.
- `frame_start`:
  - Registered; high for exactly one `clk` cycle, the cycle after `tick` wraps (799,524)→(0,0).
  - Not asserted on reset release.
- Reset (async, immediate):
  - div=0, `hcount`=0, `vcount`=0.
  - `hsync`=1, `vsync`=1, `red`/`green`/`blue`=0, `frame_start`=0.
  - `visible` reads 1, since (0,0) is visible.
- Reset mid-frame: all of the above takes effect without waiting for a clock edge. The scan restarts from (0,0) with no partial-line recovery.

## Timing
- First `tick` occurs on the `CLK_DIV`-th rising edge after `rst` deasserts.
- Line period: 800·`CLK_DIV` clks. Frame period: 420000·`CLK_DIV` clks (840000 at default).
- `hsync` is low for exactly 96 ticks per line, spanning the output periods of counter values 657..752.
- `vsync` is low for exactly 2 lines, delayed one pixel relative to `vcount` 490.
- Output registers hold their value between ticks; `rgb_in` is sampled only on `tick` edges.
- `hcount`/`vcount` change on the `tick` edge; upstream has the full `CLK_DIV` clks minus routing to settle `rgb_in`.

## Configuration
- Macro `VGA_BORDER_EN`.
- Defined: when the sampled pixel lies on the visible perimeter (`hcount` 0 or 639, or `vcount` 0 or 479), the colour register loads 8'hFF (`red`=7, `green`=7, `blue`=3), overriding `rgb_in`. Used for monitor alignment.
- Undefined: `rgb_in` passes through unmodified in the visible area; no border logic is synthesized.

## Test plan
- Reset, `CLK_DIV`=2:
  - During reset: `hsync`=1, `vsync`=1, colour 0, `hcount`=0.
  - After release: `hcount` stays 0 for 2 clks, then becomes 1.
- Line timing, default parameters: `hsync` low for exactly 192 clks per 1600-clk line; it falls 2 clks after `hcount` reaches 656.
- Frame timing: `vsync` low for 3200 clks per frame. Successive `frame_start` pulses are exactly 840000 clks apart, each 1 clk wide.
- Colour path: constant `rgb_in`=8'b11100000 gives `red`=7, `green`=0, `blue`=0 for output pixels 0..639 of lines 0..479, and all zero for pixels 640..799 and lines 480..524.
- Border, `rgb_in`=0:
  - With `VGA_BORDER_EN`: pins read 8'hFF for pixels (0,0), (639,10) and (5,479), and 0 for (1,1).
  - Without the macro: 0 at all four pixels.
- Async reset pulse at `hcount`=300, `vcount`=100, asserted between clock edges:
  - Outputs return to reset values before the next edge.
  - After release, the scan resumes at (0,0) and the next `frame_start` arrives 840000 clks later.
